// File: rtl/ysyx_23060111_mc_ctrl.sv
// Multi-cycle core sequencer: owns PC and latched instruction, walks fetch/exec/mem/wb.
// Optional macro YSYX_23060111_PERF_CNT_EN adds perf_cycle / perf_instret counters.
module ysyx_23060111_mc_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000,
    parameter int               TO_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      inst,
    output logic             if_req_valid,
    input  logic             if_req_ready,
    input  logic             if_rsp_valid,
    input  logic [31:0]      if_rsp_data,
    input  logic             dec_inv,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_rd_wen,
    input  logic             dec_ebreak,
    input  logic [XLEN-1:0]  exu_dnpc,
    output logic             ls_req_valid,
    output logic             ls_req_wen,
    input  logic             ls_req_ready,
    input  logic             ls_rsp_valid,
    output logic             rf_wen,
    output logic             halt,
    output logic             trap,
    output logic [1:0]       trap_cause,
`ifdef YSYX_23060111_PERF_CNT_EN
    output logic [63:0]      perf_cycle,
    output logic [63:0]      perf_instret,
`endif
    output logic [2:0]       dbg_state
);

    // Handshake: a request transfers on the cycle where valid && ready are both high;
    // a response is taken on any cycle its valid is high while the matching REQ/WAIT
    // state is active, including the cycle the request itself is accepted.

    typedef enum logic [2:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_LS_REQ     = 3'd3,
        S_LS_WAIT    = 3'd4,
        S_WB         = 3'd5,
        S_HALT       = 3'd6
    } state_t;

    localparam logic [TO_W-1:0] TO_MAX  = '1;
    localparam logic [TO_W-1:0] TO_LAST = TO_MAX - TO_W'(1);

    localparam logic [1:0] CAUSE_INV  = 2'b01;
    localparam logic [1:0] CAUSE_FTO  = 2'b10;
    localparam logic [1:0] CAUSE_LSTO = 2'b11;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc_nxt;
    logic [31:0]       inst_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt, to_cnt_inc;
    logic              to_hit;
    logic              halt_nxt, trap_nxt;
    logic [1:0]        cause_nxt;

    // The counter reaching its last value without a response on this cycle is a timeout.
    assign to_hit     = (to_cnt >= TO_LAST);
    assign to_cnt_inc = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH_REQ;
            pc         <= RESET_PC;
            inst       <= '0;
            to_cnt     <= '0;
            halt       <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            to_cnt     <= to_cnt_nxt;
            halt       <= halt_nxt;
            trap       <= trap_nxt;
            trap_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        inst_nxt   = inst;
        to_cnt_nxt = to_cnt;
        halt_nxt   = halt;
        trap_nxt   = trap;
        cause_nxt  = trap_cause;
        unique case (state)
            S_FETCH_REQ: begin
                to_cnt_nxt = to_cnt_inc;
                if (if_req_ready) begin
                    if (if_rsp_valid) begin
                        inst_nxt  = if_rsp_data;
                        state_nxt = S_EXEC;
                    end else begin
                        state_nxt = S_FETCH_WAIT;
                    end
                end else if (to_hit) begin
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_FTO;
                    state_nxt = S_HALT;
                end
            end
            S_FETCH_WAIT: begin
                to_cnt_nxt = to_cnt_inc;
                if (if_rsp_valid) begin
                    inst_nxt  = if_rsp_data;
                    state_nxt = S_EXEC;
                end else if (to_hit) begin
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_FTO;
                    state_nxt = S_HALT;
                end
            end
            S_EXEC: begin
                if (dec_inv) begin
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_INV;
                    state_nxt = S_HALT;
                end else if (dec_ebreak) begin
                    halt_nxt  = 1'b1;
                    state_nxt = S_HALT;
                end else if (dec_load || dec_store) begin
                    to_cnt_nxt = '0;
                    state_nxt  = S_LS_REQ;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_LS_REQ: begin
                to_cnt_nxt = to_cnt_inc;
                if (ls_req_ready) begin
                    state_nxt = ls_rsp_valid ? S_WB : S_LS_WAIT;
                end else if (to_hit) begin
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_LSTO;
                    state_nxt = S_HALT;
                end
            end
            S_LS_WAIT: begin
                to_cnt_nxt = to_cnt_inc;
                if (ls_rsp_valid) begin
                    state_nxt = S_WB;
                end else if (to_hit) begin
                    trap_nxt  = 1'b1;
                    cause_nxt = CAUSE_LSTO;
                    state_nxt = S_HALT;
                end
            end
            S_WB: begin
                pc_nxt     = exu_dnpc;
                to_cnt_nxt = '0;
                state_nxt  = S_FETCH_REQ;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    // Reset parks the FSM in FETCH_REQ, but no request may be visible while reset is held.
    assign if_req_valid = rst && (state == S_FETCH_REQ);
    assign ls_req_valid = (state == S_LS_REQ);
    assign ls_req_wen   = ls_req_valid && dec_store;
    assign rf_wen       = (state == S_WB) && dec_rd_wen && !dec_store;
    assign dbg_state    = state;

`ifdef YSYX_23060111_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else begin
            if (state != S_HALT) begin
                perf_cycle <= perf_cycle + 64'd1;
            end
            if ((state == S_WB) || (state == S_EXEC && dec_ebreak && !dec_inv)) begin
                perf_instret <= perf_instret + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060111_mc_ctrl.sv
// Self-checking bench for ysyx_23060111_mc_ctrl: bus responder with chosen delays,
// per-instruction expectations computed from cycle-budget arithmetic.
module tb_ysyx_23060111_mc_ctrl;
    localparam int          XLEN = 32;
    localparam int          TO_W = 4;
    localparam logic [31:0] RPC  = 32'h8000_0000;

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_EBRK = 3, K_INV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic              if_req_valid;
    logic              if_req_ready = 1'b0;
    logic              if_rsp_valid = 1'b0;
    logic [31:0]       if_rsp_data  = '0;
    logic              dec_inv = 1'b0, dec_load = 1'b0, dec_store = 1'b0;
    logic              dec_rd_wen = 1'b0, dec_ebreak = 1'b0;
    logic [XLEN-1:0]   exu_dnpc = '0;
    logic              ls_req_valid, ls_req_wen;
    logic              ls_req_ready = 1'b0;
    logic              ls_rsp_valid = 1'b0;
    logic              rf_wen, halt, trap;
    logic [1:0]        trap_cause;
    logic [2:0]        dbg_state;
`ifdef YSYX_23060111_PERF_CNT_EN
    logic [63:0]       perf_cycle, perf_instret;
`endif

    int tests = 0;
    int fails = 0;

    // Results of the last do_inst call
    int r_cyc, r_ifv, r_lsv, r_rf, r_wen, r_ovl;
    bit r_done;

    always #5 clk = ~clk;

    ysyx_23060111_mc_ctrl #(.XLEN(XLEN), .RESET_PC(RPC), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dec_inv(dec_inv), .dec_load(dec_load), .dec_store(dec_store),
        .dec_rd_wen(dec_rd_wen), .dec_ebreak(dec_ebreak), .exu_dnpc(exu_dnpc),
        .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen),
        .ls_req_ready(ls_req_ready), .ls_rsp_valid(ls_rsp_valid),
        .rf_wen(rf_wen), .halt(halt), .trap(trap), .trap_cause(trap_cause),
`ifdef YSYX_23060111_PERF_CNT_EN
        .perf_cycle(perf_cycle), .perf_instret(perf_instret),
`endif
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        if_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        ls_req_ready = 1'b0;
        ls_rsp_valid = 1'b0;
    endtask

    // Expected cycles from the start of an instruction until its effect is visible.
    // A response given with the accepting handshake skips the WAIT state entirely.
    function automatic int exp_cycles(input int kind, input int f_rdy, f_rsp, l_rdy, l_rsp);
        int fetch;
        fetch = f_rdy + 1 + f_rsp;
        if (kind == K_EBRK || kind == K_INV) return fetch + 1;
        if (kind == K_LD || kind == K_ST) return fetch + 1 + (l_rdy + 1 + l_rsp) + 1;
        return fetch + 1 + 1;
    endfunction

    // Acts as both buses for one instruction. Called at a falling edge; returns at a
    // falling edge where pc has moved, halt/trap is up, or the cycle limit ran out.
    task automatic do_inst(input int kind, input bit rd_wen, input int f_rdy, input int f_rsp,
                           input int l_rdy, input int l_rsp, input logic [31:0] dnpc,
                           input logic [31:0] data, input int limit);
        logic [31:0] pc0;
        int n_f, n_l, fw, lw;
        bit f_acc, f_done, l_acc, l_done;
        n_f = 0; n_l = 0; fw = 0; lw = 0;
        f_acc = 0; f_done = 0; l_acc = 0; l_done = 0;
        r_cyc = 0; r_ifv = 0; r_lsv = 0; r_rf = 0; r_wen = 0; r_ovl = 0; r_done = 0;
        dec_inv    = (kind == K_INV);
        dec_load   = (kind == K_LD);
        dec_store  = (kind == K_ST);
        dec_ebreak = (kind == K_EBRK);
        dec_rd_wen = rd_wen;
        exu_dnpc   = dnpc;
        if_rsp_data = data;
        #1;
        pc0 = pc;
        for (int c = 0; c < limit; c++) begin
            if (c != 0) @(negedge clk);
            idle_bus();
            if (pc !== pc0 || halt === 1'b1 || trap === 1'b1) begin
                r_done = 1;
                break;
            end
            r_cyc++;
            if (rf_wen) r_rf++;
            if (rf_wen && ls_req_valid) r_ovl++;
            if (ls_req_valid && ls_req_wen) r_wen++;
            if (if_req_valid) begin
                if_req_ready = (n_f == f_rdy);
                if_rsp_valid = if_req_ready && (f_rsp == 0);
                n_f++;
                if (if_req_ready) begin f_acc = 1; f_done = (f_rsp == 0); fw = 0; end
            end else if (f_acc && !f_done) begin
                fw++;
                if (fw == f_rsp) begin if_rsp_valid = 1'b1; f_done = 1; end
            end
            if (ls_req_valid) begin
                ls_req_ready = (n_l == l_rdy);
                ls_rsp_valid = ls_req_ready && (l_rsp == 0);
                n_l++;
                if (ls_req_ready) begin l_acc = 1; l_done = (l_rsp == 0); lw = 0; end
            end else if (l_acc && !l_done) begin
                lw++;
                if (lw == l_rsp) begin ls_rsp_valid = 1'b1; l_done = 1; end
            end
        end
        r_ifv = n_f;
        r_lsv = n_l;
        if (!r_done) idle_bus();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RPC);
        check("rst_halt", halt, 0);
        check("rst_trap", trap, 0);
        check("rst_ifv", if_req_valid, 0);
        rst = 1'b1;
        #1;
    endtask

    // Watch a halted core for n cycles: no requests, nothing moves.
    task automatic watch_frozen(input string tag, input logic [31:0] pc_exp,
                                input logic [31:0] inst_exp, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (if_req_valid || ls_req_valid || rf_wen) bad++;
            if (pc !== pc_exp || inst !== inst_exp) bad++;
            if (halt && trap) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic run_checked(input string tag, input int kind, input bit rd_wen,
                               input int f_rdy, input int f_rsp, input int l_rdy,
                               input int l_rsp, input logic [31:0] dnpc, input logic [31:0] data);
        bit mem;
        mem = (kind == K_LD || kind == K_ST);
        do_inst(kind, rd_wen, f_rdy, f_rsp, l_rdy, l_rsp, dnpc, data, 200);
        check({tag, "_done"}, r_done, 1);
        check({tag, "_cyc"}, r_cyc, exp_cycles(kind, f_rdy, f_rsp, l_rdy, l_rsp));
        check({tag, "_ifv"}, r_ifv, f_rdy + 1);
        check({tag, "_lsv"}, r_lsv, mem ? l_rdy + 1 : 0);
        check({tag, "_rf"}, r_rf, (rd_wen && kind != K_ST) ? 1 : 0);
        check({tag, "_wen"}, r_wen, (kind == K_ST) ? l_rdy + 1 : 0);
        check({tag, "_ovl"}, r_ovl, 0);
        check({tag, "_pc"}, pc, dnpc);
        check({tag, "_inst"}, inst, data);
    endtask

    initial begin
        logic [31:0] dn, dat, pc_hold;
        int kind;

        // Reset state
        #2;
        repeat (2) @(negedge clk);
        check("r0_pc", pc, RPC);
        check("r0_inst", inst, 0);
        check("r0_ifv", if_req_valid, 0);
        check("r0_lsv", ls_req_valid, 0);
        check("r0_rf", rf_wen, 0);
        check("r0_flags", {halt, trap, trap_cause}, 0);
        rst = 1'b1;
        #1;

        // ALU, buses ready immediately: 8000_0000 -> 8000_0004, one rf_wen pulse
        run_checked("alu0", K_ALU, 1, 0, 0, 0, 0, RPC + 32'd4, 32'h0000_0013);
        // Load, request accepted after 3 wait cycles, data 2 cycles later
        run_checked("ld0", K_LD, 1, 0, 0, 3, 2, RPC + 32'd8, 32'h0000_2083);
        // Store that claims rd: writes memory, never the register file
        run_checked("st0", K_ST, 1, 1, 1, 0, 1, RPC + 32'd12, 32'h0010_2023);

        // Random instruction mix
        for (int i = 0; i < 20; i++) begin
            kind = $urandom_range(0, 2);
            dn = $urandom;
            if (dn == pc) dn = dn ^ 32'h4;
            dat = $urandom;
            run_checked("rnd", kind, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), dn, dat);
        end
`ifdef YSYX_23060111_PERF_CNT_EN
        check("perf_instret", perf_instret, 64'd23);
`endif

        // Fetch response on the last permitted cycle (15th with TO_W=4) wins
        dn = pc + 32'd4;
        run_checked("to_edge", K_ALU, 1, 0, 14, 0, 0, dn, 32'h1234_5678);
        check("to_edge_trap", trap, 0);

        // Fetch response withheld: trap on cycle 15, cause 10, core frozen
        pc_hold = pc;
        dat = inst;
        do_inst(K_ALU, 1, 0, 1000, 0, 0, pc + 32'd4, 32'hdead_beef, 100);
        check("fto_done", r_done, 1);
        check("fto_cyc", r_cyc, 15);
        check("fto_trap", trap, 1);
        check("fto_cause", trap_cause, 2'b10);
        check("fto_halt", halt, 0);
        check("fto_pc", pc, pc_hold);
        watch_frozen("fto_frozen", pc_hold, dat, 6);

        // Load/store response withheld: cause 11
        do_reset();
        do_inst(K_LD, 1, 0, 0, 0, 1000, RPC + 32'd4, 32'h0000_2083, 100);
        check("lto_cyc", r_cyc, 17);
        check("lto_trap", trap, 1);
        check("lto_cause", trap_cause, 2'b11);
        check("lto_pc", pc, RPC);

        // Invalid opcode: trap cause 01, no further fetches
        do_reset();
        dat = 32'hffff_ffff;
        do_inst(K_INV, 1, 2, 1, 0, 0, RPC + 32'd4, dat, 100);
        check("inv_cyc", r_cyc, exp_cycles(K_INV, 2, 1, 0, 0));
        check("inv_trap", trap, 1);
        check("inv_cause", trap_cause, 2'b01);
        check("inv_halt", halt, 0);
        watch_frozen("inv_frozen", RPC, dat, 8);

        // ebreak: halt, not trap, frozen
        do_reset();
        dat = 32'h0010_0073;
        do_inst(K_EBRK, 0, 0, 1, 0, 0, RPC + 32'd4, dat, 100);
        check("ebrk_cyc", r_cyc, exp_cycles(K_EBRK, 0, 1, 0, 0));
        check("ebrk_halt", halt, 1);
        check("ebrk_trap", trap, 0);
`ifdef YSYX_23060111_PERF_CNT_EN
        check("ebrk_instret", perf_instret, 64'd1);
`endif
        watch_frozen("ebrk_frozen", RPC, dat, 6);

        // Reset clears halt; then abandon a load while waiting on its response
        do_reset();
        check("post_halt", halt, 0);
        do_inst(K_LD, 1, 0, 0, 0, 1000, RPC + 32'd40, 32'h0000_2083, 5);
        check("midls_open", r_done, 0);
        check("midls_rf", rf_wen, 0);
        check("midls_lsv", ls_req_valid, 0);
        #2 rst = 1'b0;
        #1;
        check("midls_rst_pc", pc, RPC);
        check("midls_rst_ifv", if_req_valid, 0);
        check("midls_rst_flags", {halt, trap, trap_cause}, 0);
        @(negedge clk);
        rst = 1'b1;
        ls_rsp_valid = 1'b1;
        @(negedge clk);
        ls_rsp_valid = 1'b0;
        check("stray_rsp_pc", pc, RPC);
        run_checked("after_rst", K_ALU, 1, 1, 0, 0, 0, RPC + 32'd4, 32'h0000_0093);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

endmodule
